// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: stalls the pipe while
// it works, then pulses one HI/LO write. Divide is 32-step radix-2 restoring.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall_o,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        is_signed;
  logic        sign_a;
  logic        sign_b;
  // For divide, opa is the dividend shift register that fills with quotient bits.
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] rem;

  logic        accept;
  logic        signed_op;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] product;

  assign accept    = (state == IDLE) && start && !cancel;
  assign stall_o   = accept || ((state == BUSY) && !cancel);
  assign signed_op = ~op[0];

  // NOTE: every always_comb output gets a value on every path, so no latches appear.
  always_comb begin
    abs_a    = (signed_op && src_a[31]) ? -src_a : src_a;
    abs_b    = (signed_op && src_b[31]) ? -src_b : src_b;
    trial    = {rem, opa[31]} - {1'b0, opb};
    rem_next = trial[32] ? {rem[30:0], opa[31]} : trial[31:0];
    quo_next = {opa[30:0], ~trial[32]};
    div_lo   = (sign_a ^ sign_b) ? -quo_next : quo_next;
    div_hi   = sign_a ? -rem_next : rem_next;
    // Extending to 64 bits first makes the low 64 bits of the product exact for both signednesses.
    ma       = {{32{is_signed & opa[31]}}, opa};
    mb       = {{32{is_signed & opb[31]}}, opb};
    product  = ma * mb;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      rem       <= '0;
      hilo_we   <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            rem       <= '0;
            is_div    <= op[1];
            is_signed <= signed_op;
            sign_a    <= op[1] & signed_op & src_a[31];
            sign_b    <= op[1] & signed_op & src_b[31];
            if (op[1] && (src_b == 32'd0)) begin
              hi_o    <= src_a;
              lo_o    <= 32'hFFFF_FFFF;
              hilo_we <= 1'b1;
              state   <= DONE;
            end else begin
              opa   <= op[1] ? abs_a : src_a;
              opb   <= op[1] ? abs_b : src_b;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cancel) begin
            state <= IDLE;
          end else if (is_div) begin
            rem <= rem_next;
            opa <= quo_next;
            cnt <= cnt + 5'd1;
            if (cnt == DIV_LAST) begin
              hi_o    <= div_hi;
              lo_o    <= div_lo;
              hilo_we <= 1'b1;
              state   <= DONE;
            end
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt == MUL_LAST) begin
              hi_o    <= product[63:32];
              lo_o    <= product[31:0];
              hilo_we <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver pushes model results with their
// expected write cycle; a negedge monitor pops and compares on each hilo_we.
module tb_muldiv_ctrl;

  localparam int MUL_CYCLES = 2;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        cancel = 1'b0;
  logic        stall_o;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   pushes = 0;
  exp_t sb[$];

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .stall_o(stall_o), .hilo_we(hilo_we),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural definition.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sbv;
    sa  = a;
    sbv = b;
    lat = 1 + MUL_CYCLES;
    hi  = '0;
    lo  = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sbv);
        hi = sp[63:32];
        lo = sp[31:0];
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        lat = 33;
        if (b == 32'd0) begin
          hi  = a;
          lo  = 32'hFFFF_FFFF;
          lat = 1;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else if (o == 2'b10) begin
          lo = sa / sbv;
          hi = sa % sbv;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int t, output int lat);
    exp_t e;
    model(o, a, b, e.hi, e.lo, lat);
    e.cyc = t + lat;
    sb.push_back(e);
    pushes++;
  endtask

  // Waits (bounded) until every expected write has been seen.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      check("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int t;
    int lat;
    step();
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check("stall_accept", 64'(stall_o), 64'd1);
    t = cyc;
    push(o, a, b, t, lat);
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      check("stall_busy", 64'(stall_o), 64'(cyc < t + lat));
      step();
    end
    if (sb.size() != 0) begin
      check("timeout_op", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    check("stall_done", 64'(stall_o), 64'd0);
  endtask

  // Monitor: every write strobe must match the oldest expectation, value and cycle.
  always @(negedge clk) begin
    if (resetn && hilo_we) begin
      pulses++;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", 64'(hi_o), 64'(e.hi));
        check("lo", 64'(lo_o), 64'(e.lo));
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          lat;
    int          p0;
    logic [31:0] save_hi;
    logic [31:0] save_lo;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    step();
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_we", 64'(hilo_we), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    step();
    resetn = 1'b1;
    step();

    // Cancel together with start in IDLE is not accepted.
    start = 1'b1; cancel = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd4;
    #1;
    check("cancel_idle_stall", 64'(stall_o), 64'd0);
    step();
    step();
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle_hold", 64'({hi_o, lo_o}), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h1234_5678, 32'd0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE);

    // Cancel mid-divide, then a new MULT right after.
    save_hi = hi_o; save_lo = lo_o;
    step();
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    t = cyc;
    while (cyc < t + 10) step();
    cancel = 1'b1;
    #1;
    check("cancel_stall_drop", 64'(stall_o), 64'd0);
    step();
    cancel = 1'b0;
    check("cancel_hi_hold", 64'(hi_o), 64'(save_hi));
    check("cancel_lo_hold", 64'(lo_o), 64'(save_lo));
    op = 2'b00; src_a = 32'd6; src_b = 32'hFFFF_FFF9;
    #1;
    check("post_cancel_accept", 64'(stall_o), 64'd1);
    push(2'b00, 32'd6, 32'hFFFF_FFF9, cyc, lat);
    step();
    start = 1'b0;
    drain(20);

    // Back-to-back DIVU then MULT with start held across DONE.
    p0 = pulses;
    step();
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    t = cyc;
    push(2'b11, 32'd100, 32'd7, t, lat);
    push(2'b00, 32'hFFFF_FFFD, 32'd5, t + 34, lat);
    step();
    op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      if (cyc >= t + 35) start = 1'b0;
      step();
    end
    start = 1'b0;
    drain(5);
    step();
    step();
    check("b2b_pulses", 64'(pulses - p0), 64'd2);

    // Reset in the middle of a divide: outputs clear immediately, nothing written.
    step();
    start = 1'b1; op = 2'b11; src_a = 32'd999; src_b = 32'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    #1;
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_we", 64'(hilo_we), 64'd0);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_lo", 64'(lo_o), 64'd0);
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("midrst_no_write", 64'({hi_o, lo_o}), 64'd0);

    // Randomized mix with biased divisors.
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(o, a, b);
    end

    step();
    check("pulse_count", 64'(pulses), 64'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
